// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
// Imported by serial_subtractor and full_subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bin, bo = borrow out.
// Purely combinational, gate primitives only.
module full_subtractor
  import serial_sub_pkg::*;
(
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bin
);

  logic t;
  logic x_n;
  logic t_n;
  logic p;
  logic q;

  xor g_t  (t, x, y);
  xor g_d  (d, t, bin);
  not g_xn (x_n, x);
  not g_tn (t_n, t);
  and g_p  (p, x_n, y);
  and g_q  (q, t_n, bin);
  or  g_bo (bo, p, q);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, diff = a - b over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  import serial_sub_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sa_d;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sb_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             br_q;
  logic             br_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             cell_d;
  logic             cell_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  full_subtractor u_fs (
    .d   (cell_d),
    .bo  (cell_bo),
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (br_q)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = cell_bo;
        if (cnt_q == LAST) begin
          state_d = DONE;
          // sa/sb bit 0 now hold the operand MSBs
`ifdef SERIAL_SUB_OVF_EN
          ovf_d = (sa_q[0] ^ sb_q[0]) & (cell_d ^ sa_q[0]);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = res_q;
  assign borrow_out = br_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks for serial_subtractor, WIDTH=8.
// Covers latency, borrow, backpressure, mid-op reset and no-overlap.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept a/b and wait for out_valid; returns cycles after accept edge
  task automatic launch(input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        output int n);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic op(input string tag,
                    input logic [W-1:0] va,
                    input logic [W-1:0] vb,
                    input logic [W-1:0] ed,
                    input logic         ebo,
                    input logic         eovf);
    int n;
    chk({tag, "_in_ready"}, in_ready, 1);
    launch(va, vb, n);
    chk({tag, "_latency"}, n, W);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, ebo);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eovf);
`else
    if (eovf === 1'bx) $display("unreachable");
`endif
    step();
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_ov_low"}, out_valid, 0);
  endtask

  initial begin
    int           n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] hd;
    logic [W-1:0] hbo;
    logic [W:0]   full;
    logic         eovf;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    step();

    op("5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    op("00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op("80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op("3c_3c", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    op("ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

    // backpressure: 0x01 - 0x80 = 0x81, borrow, signed overflow
    out_ready = 1'b0;
    launch(8'h01, 8'h80, n);
    chk("bp_latency", n, W);
    for (int i = 0; i < 5; i++) begin
      chk("bp_diff", diff, 8'h81);
      chk("bp_borrow", borrow_out, 1);
`ifdef SERIAL_SUB_OVF_EN
      chk("bp_ovf", ovf, 1);
`endif
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", in_ready, 1);
    chk("bp_ov_low", out_valid, 0);

    // reset sampled at the 4th BUSY edge
    a        = 8'hAA;
    b        = 8'h55;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    op("10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    // back-to-back random pairs with in_valid held high
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      full = {1'b0, ra} - {1'b0, rb};
      hd   = full[W-1:0];
      hbo  = {7'd0, (ra < rb)};
      eovf = (ra[W-1] != rb[W-1]) && (hd[W-1] != ra[W-1]);
      chk("rnd_accept_ready", in_ready, 1);
      a = ra;
      b = rb;
      step();
      for (int k = 0; k < W; k++) begin
        chk("rnd_busy_in_ready", in_ready, 0);
        chk("rnd_busy_out_valid", out_valid, 0);
        a         = 8'($urandom);
        b         = 8'($urandom);
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        step();
      end
      chk("rnd_out_valid", out_valid, 1);
      chk("rnd_in_ready_done", in_ready, 0);
      chk("rnd_diff", diff, hd);
      chk("rnd_borrow", borrow_out, hbo[0]);
`ifdef SERIAL_SUB_OVF_EN
      chk("rnd_ovf", ovf, eovf);
`else
      if (eovf === 1'bx) $display("unreachable");
`endif
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("rnd_end_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
